// File: rtl/control_seq.sv
// Instruction sequencer for a small single-cycle datapath: decodes Opcode into
// datapath strobes and steps through boot, free-run, single-step, halt and fault.
module control_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  Opcode,
    input  logic        zero,
    input  logic        run,
    input  logic        step,
    input  logic        resume,
    output logic        s_inc,
    output logic        s_inm,
    output logic        we,
    output logic        wez,
    output logic [2:0]  ALUOp,
    output logic        pc_en,
    output logic        halted,
    output logic        fault,
    output logic [15:0] retired
);

    localparam int unsigned ST_W  = 3;
    localparam int unsigned RET_W = 16;
    localparam int unsigned ALU_W = 3;

    localparam logic [ST_W-1:0] BOOT      = 3'd0;
    localparam logic [ST_W-1:0] EXEC      = 3'd1;
    localparam logic [ST_W-1:0] WAIT_STEP = 3'd2;
    localparam logic [ST_W-1:0] HALT      = 3'd3;
    localparam logic [ST_W-1:0] FAULT     = 3'd4;

    logic [ST_W-1:0]  state_q, state_d;
    logic [RET_W-1:0] retired_q, retired_d;

    logic             s_inc_c, s_inm_c, we_c, wez_c, pc_en_c, halted_c, fault_c;
    logic [ALU_W-1:0] alu_op_c;

    // Opcode classification; Opcode[1:0] carries no control information
    logic [3:0] op_grp;
    logic       is_illegal, is_halt, is_jump, is_ldi;
    logic       unused_opcode_bits;

    assign op_grp             = Opcode[5:2];
    assign is_illegal         = (Opcode[5:4] == 2'b11);
    assign is_halt            = (op_grp == 4'b1011);
    assign is_jump            = (Opcode[5:4] == 2'b10) && (Opcode[3:2] != 2'b11);
    assign is_ldi             = (op_grp == 4'b0000);
    assign unused_opcode_bits = ^Opcode[1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= BOOT;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Next state, retire count and combinational decode
    always_comb begin
        state_d   = state_q;
        retired_d = retired_q;
        s_inc_c   = 1'b0;
        s_inm_c   = 1'b0;
        we_c      = 1'b0;
        wez_c     = 1'b0;
        alu_op_c  = '0;
        pc_en_c   = 1'b0;
        halted_c  = 1'b0;
        fault_c   = 1'b0;

        case (state_q)
            BOOT: begin
                state_d = run ? EXEC : WAIT_STEP;
            end
            EXEC: begin
                if (is_illegal) begin
                    state_d = FAULT;
                end else begin
                    retired_d = retired_q + RET_W'(1);
                    if (is_halt) begin
                        state_d = HALT;
                    end else begin
                        pc_en_c = 1'b1;
                        state_d = run ? EXEC : WAIT_STEP;
                        if (is_jump) begin
                            case (Opcode[3:2])
                                2'b00:   s_inc_c = 1'b1;
                                2'b01:   s_inc_c = zero;
                                default: s_inc_c = ~zero;
                            endcase
                        end else if (is_ldi) begin
                            s_inm_c = 1'b1;
                            we_c    = 1'b1;
                        end else begin
                            alu_op_c = Opcode[4:2];
                            we_c     = 1'b1;
                            wez_c    = 1'b1;
                        end
                    end
                end
            end
            WAIT_STEP: begin
                if (step || run) begin
                    state_d = EXEC;
                end
            end
            HALT: begin
                halted_c = 1'b1;
                // PC steps past the HALT word in the cycle we leave
                if (resume) begin
                    pc_en_c = 1'b1;
                    state_d = run ? EXEC : WAIT_STEP;
                end
            end
            FAULT: begin
                fault_c = 1'b1;
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign s_inc   = s_inc_c;
    assign s_inm   = s_inm_c;
    assign we      = we_c;
    assign wez     = wez_c;
    assign ALUOp   = alu_op_c;
    assign pc_en   = pc_en_c;
    assign halted  = halted_c;
    assign fault   = fault_c;
    assign retired = retired_q;

endmodule

// File: tb/tb_control_seq.sv
// Self-checking bench for control_seq against a rule-level reference model.
module tb_control_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  Opcode;
    logic        zero, run, step, resume;
    logic        s_inc, s_inm, we, wez, pc_en, halted, fault;
    logic [2:0]  ALUOp;
    logic [15:0] retired;
    logic [9:0]  got;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int M_BOOT  = 0;
    localparam int M_EXEC  = 1;
    localparam int M_WAIT  = 2;
    localparam int M_HALT  = 3;
    localparam int M_FAULT = 4;

    localparam logic [5:0] OP_ALU3 = 6'b001100;
    localparam logic [5:0] OP_JZ   = 6'b100100;
    localparam logic [5:0] OP_HALT = 6'b101100;
    localparam logic [5:0] OP_ILL  = 6'b110000;

    int          mode;
    int unsigned ref_retired;

    control_seq dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .zero(zero), .run(run),
        .step(step), .resume(resume), .s_inc(s_inc), .s_inm(s_inm), .we(we),
        .wez(wez), .ALUOp(ALUOp), .pc_en(pc_en), .halted(halted),
        .fault(fault), .retired(retired)
    );

    always #5 clk = ~clk;

    // {s_inc, s_inm, we, wez, ALUOp[2:0], pc_en, halted, fault}
    assign got = {s_inc, s_inm, we, wez, ALUOp, pc_en, halted, fault};

    function automatic logic [9:0] ref_out(int m, logic [5:0] op, logic z, logic res);
        int         grp = int'(op) / 4;
        logic [9:0] o   = '0;
        if (m == M_EXEC) begin
            if (grp < 8) begin
                o[2] = 1'b1;
                o[7] = 1'b1;
                if (grp == 0) o[8] = 1'b1;
                else begin
                    o[6]   = 1'b1;
                    o[5:3] = 3'(grp);
                end
            end else if (grp == 8) begin
                o[9] = 1'b1;  o[2] = 1'b1;
            end else if (grp == 9) begin
                o[9] = z;     o[2] = 1'b1;
            end else if (grp == 10) begin
                o[9] = !z;    o[2] = 1'b1;
            end
        end else if (m == M_HALT) begin
            o[1] = 1'b1;
            o[2] = res;
        end else if (m == M_FAULT) begin
            o[0] = 1'b1;
        end
        return o;
    endfunction

    function automatic int ref_next(int m, logic [5:0] op, logic r, logic s, logic res);
        int after = r ? M_EXEC : M_WAIT;
        case (m)
            M_BOOT:  return after;
            M_EXEC:  return (op >= 6'd48) ? M_FAULT : (op[5:2] == 4'd11) ? M_HALT : after;
            M_WAIT:  return (s || r) ? M_EXEC : M_WAIT;
            M_HALT:  return res ? after : M_HALT;
            default: return M_FAULT;
        endcase
    endfunction

    task automatic drive(input logic [5:0] op, input logic z, input logic r,
                         input logic s, input logic res);
        Opcode = op; zero = z; run = r; step = s; resume = res;
        @(negedge clk);
    endtask

    task automatic tick();
        int nm;
        nm = ref_next(mode, Opcode, run, step, resume);
        if (mode == M_EXEC && Opcode < 6'd48) ref_retired = (ref_retired + 1) & 32'hFFFF;
        @(posedge clk);
        mode = nm;
        #1;
    endtask

    task automatic do_reset(input logic r);
        reset = 1'b0;
        Opcode = OP_ALU3; zero = 1'b0; run = r; step = 1'b0; resume = 1'b0;
        #2;
        mode = M_BOOT;
        ref_retired = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; Opcode = OP_ALU3; zero = 1'b0; run = 1'b1; step = 1'b0; resume = 1'b0;
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (got !== 10'd0 || retired !== 16'd0) begin
            n_fail++; $display("FAIL reset_async: outputs %b retired %h, required all zero", got, retired);
        end
        mode = M_BOOT; ref_retired = 0;
        @(posedge clk); #1 reset = 1'b1;
        drive(OP_ALU3, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (got !== 10'd0) begin
            n_fail++; $display("FAIL boot_cycle: outputs %b, required 0", got);
        end
        tick();
        drive(OP_ALU3, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (got !== ref_out(mode, Opcode, zero, resume) || mode != M_EXEC) begin
            n_fail++; $display("FAIL first_exec: outputs %b, required %b", got, ref_out(mode, Opcode, zero, resume));
        end
        tick();
    endtask

    task automatic test_alu();
        for (int i = 0; i < 8; i++) begin
            drive(OP_ALU3, i[0], 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (got !== 10'b0011011100 || retired !== 16'(ref_retired)) begin
                n_fail++; $display("FAIL alu_reg_reg: outputs %b retired %0d, required 0011011100 retired %0d",
                                   got, retired, ref_retired);
            end
            tick();
        end
    endtask

    task automatic test_jz();
        for (int i = 0; i < 4; i++) begin
            drive(OP_JZ, i[0], 1'b1, 1'b0, 1'b0);
            n_checks++;
            if ({s_inc, we, wez, pc_en} !== {i[0], 3'b001}) begin
                n_fail++; $display("FAIL jz: zero=%0d s_inc/we/wez/pc_en %b, required %b",
                                   i[0], {s_inc, we, wez, pc_en}, {i[0], 3'b001});
            end
            tick();
        end
    endtask

    task automatic test_halt_resume();
        int unsigned r0;
        r0 = ref_retired;
        drive(OP_HALT, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (got !== 10'd0) begin
            n_fail++; $display("FAIL halt_decode: outputs %b, required 0", got);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(6'($urandom_range(0, 47)), 1'($urandom), 1'b1, 1'($urandom), 1'b0);
            n_checks++;
            if (got !== 10'b0000000010 || retired !== 16'(r0 + 1)) begin
                n_fail++; $display("FAIL halt_hold: outputs %b retired %0d, required 0000000010 retired %0d",
                                   got, retired, r0 + 1);
            end
            tick();
        end
        drive(OP_HALT, 1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (got !== 10'b0000000110) begin
            n_fail++; $display("FAIL halt_resume: outputs %b, required 0000000110", got);
        end
        tick();
        drive(OP_ALU3, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (halted !== 1'b0 || pc_en !== 1'b1 || retired !== 16'(r0 + 1)) begin
            n_fail++; $display("FAIL halt_exit: halted %b pc_en %b retired %0d, required 0 1 %0d",
                               halted, pc_en, retired, r0 + 1);
        end
        tick();
    endtask

    task automatic test_single_step();
        int pc_cnt = 0;
        do_reset(1'b0);
        drive(OP_ALU3, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 12; i++) begin
            drive(OP_ALU3, 1'b0, 1'b0, (i % 4 == 0), 1'b0);
            n_checks++;
            if (got !== ref_out(mode, Opcode, zero, resume)) begin
                n_fail++; $display("FAIL single_step cyc %0d: outputs %b, required %b",
                                   i, got, ref_out(mode, Opcode, zero, resume));
            end
            if (pc_en === 1'b1) pc_cnt++;
            tick();
        end
        @(negedge clk);
        n_checks++;
        if (pc_cnt != 3 || retired !== 16'd3) begin
            n_fail++; $display("FAIL single_step_count: pc_en cycles %0d retired %0d, required 3 and 3",
                               pc_cnt, retired);
        end
    endtask

    task automatic test_fault();
        do_reset(1'b1);
        drive(OP_ALU3, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drive(OP_ALU3, 1'b0, 1'b1, 1'b0, 1'b0); tick();
        drive(OP_ILL, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (got !== 10'd0) begin
            n_fail++; $display("FAIL illegal_decode: outputs %b, required 0", got);
        end
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            n_checks++;
            if (got !== 10'b0000000001 || retired !== 16'd1) begin
                n_fail++; $display("FAIL fault_sticky: outputs %b retired %0d, required 0000000001 retired 1",
                                   got, retired);
            end
            tick();
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if (got !== 10'd0 || retired !== 16'd0) begin
            n_fail++; $display("FAIL fault_reset: outputs %b retired %0d, required 0", got, retired);
        end
        do_reset(1'b1);
    endtask

    task automatic test_random();
        logic [5:0] op;
        do_reset(1'($urandom));
        for (int i = 0; i < 400; i++) begin
            if (mode == M_FAULT) do_reset(1'($urandom));
            op = 6'($urandom_range(0, 63));
            if (op >= 6'd48 && $urandom_range(0, 7) != 0) op = op - 6'd16;
            drive(op, 1'($urandom), ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0));
            n_checks++;
            if (got !== ref_out(mode, Opcode, zero, resume) || retired !== 16'(ref_retired)) begin
                n_fail++; $display("FAIL random cyc %0d op %b: outputs %b retired %0d, required %b retired %0d",
                                   i, op, got, retired, ref_out(mode, Opcode, zero, resume), ref_retired);
            end
            tick();
        end
    endtask

    task automatic test_wrap_and_async();
        do_reset(1'b1);
        drive(OP_ALU3, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 65535; i++) tick();
        @(negedge clk);
        n_checks++;
        if (retired !== 16'hFFFF) begin
            n_fail++; $display("FAIL retired_full: retired %h, required FFFF", retired);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (retired !== 16'h0000) begin
            n_fail++; $display("FAIL retired_wrap: retired %h, required 0000", retired);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (retired !== 16'h0001 || got !== 10'b0011011100) begin
            n_fail++; $display("FAIL post_wrap: retired %h outputs %b, required 0001 0011011100", retired, got);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (got !== 10'd0 || retired !== 16'd0) begin
            n_fail++; $display("FAIL reset_mid_exec: outputs %b retired %h, required 0", got, retired);
        end
        do_reset(1'b1);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_jz();
        test_halt_resume();
        test_single_step();
        test_fault();
        test_random();
        test_wrap_and_async();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
